// File: rtl/arb_pkg.sv
// Shared types and constants for the instruction/data SRAM bus arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    // kseg0 and kseg1 both start with 2'b10 and fold onto the low 512 MiB.
    localparam logic [1:0]  KSEG01_TOP = 2'b10;
    localparam int          PHYS_W     = 29;
    localparam logic [31:0] PHYS_MASK  = (32'd1 << PHYS_W) - 32'd1;

endpackage

// File: rtl/sram_bus_arbiter_addr_map.sv
// Virtual-to-physical translation for the unmapped MIPS segments.
module addr_map
    import arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] vaddr_i,
    output logic [ADDR_W-1:0] paddr_o
);

    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(PHYS_MASK);

    always_comb begin
        if (vaddr_i[ADDR_W-1 -: 2] == KSEG01_TOP) begin
            paddr_o = vaddr_i & MASK;
        end else begin
            paddr_o = vaddr_i;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the core's instruction and data ports,
// one transaction at a time, data first, and freezes the pipeline meanwhile.
module sram_bus_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                stall,

    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                inst_served_q, inst_served_d;
    logic                data_served_q, data_served_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_wr_q, mem_wr_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;

    logic                inst_pend;
    logic                data_pend;
    logic                owner_live;
    logic [ADDR_W-1:0]   issue_vaddr;
    logic [ADDR_W-1:0]   issue_paddr;

    assign inst_pend = inst_req & ~inst_served_q;
    assign data_pend = data_req & ~data_served_q;
    assign stall     = inst_pend | data_pend;

    assign issue_vaddr = data_pend ? data_addr : inst_addr;

    addr_map #(
        .ADDR_W (ADDR_W)
    ) u_addr_map (
        .vaddr_i (issue_vaddr),
        .paddr_o (issue_paddr)
    );

    // A flushed requester still lets its bus transaction finish, but the
    // returned word must not be recorded as served.
    assign owner_live = (owner_q == OWN_DATA) ? data_req :
                        (owner_q == OWN_INST) ? inst_req : 1'b0;

    always_comb begin
        // NOTE: every _d starts at its _q so no path through the case leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        owner_d       = owner_q;
        inst_served_d = inst_served_q;
        data_served_d = data_served_q;
        mem_req_d     = mem_req_q;
        mem_wr_d      = mem_wr_q;
        mem_wstrb_d   = mem_wstrb_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        inst_rdata_d  = inst_rdata_q;
        data_rdata_d  = data_rdata_q;

        // The pipeline advances on any edge without stall, so the next
        // instruction's requests must be treated as new.
        if (!stall) begin
            inst_served_d = 1'b0;
            data_served_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (data_pend) begin
                    mem_req_d   = 1'b1;
                    mem_wr_d    = |data_wen;
                    mem_wstrb_d = data_wen;
                    mem_addr_d  = issue_paddr;
                    mem_wdata_d = data_wdata;
                    owner_d     = OWN_DATA;
                    state_d     = ST_ADDR;
                end else if (inst_pend) begin
                    mem_req_d   = 1'b1;
                    mem_wr_d    = 1'b0;
                    mem_wstrb_d = '0;
                    mem_addr_d  = issue_paddr;
                    mem_wdata_d = '0;
                    owner_d     = OWN_INST;
                    state_d     = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (mem_addr_ok) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (mem_data_ok) begin
                    if (owner_live) begin
                        if (owner_q == OWN_DATA) begin
                            data_rdata_d  = mem_rdata;
                            data_served_d = 1'b1;
                        end else begin
                            inst_rdata_d  = mem_rdata;
                            inst_served_d = 1'b1;
                        end
                    end
                    owner_d = OWN_NONE;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments keep every register updating from the
    // same pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_NONE;
            inst_served_q <= 1'b0;
            data_served_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_wstrb_q   <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            inst_rdata_q  <= '0;
            data_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            inst_served_q <= inst_served_d;
            data_served_q <= data_served_d;
            mem_req_q     <= mem_req_d;
            mem_wr_q      <= mem_wr_d;
            mem_wstrb_q   <= mem_wstrb_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            inst_rdata_q  <= inst_rdata_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_wr     = mem_wr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard bench for sram_bus_arbiter: a randomised slave, expected bus
// transactions and read-back words queued at issue, checked by monitors.
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok = 1'b0;
    logic        mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [31:0] irdata;
        logic [31:0] drdata;
    } rd_t;

    bus_t        exp_bus[$];
    rd_t         exp_rd[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_inst_rd = '0;
    logic [31:0] m_data_rd = '0;

    // slave behaviour knobs
    int a_min = 0, a_max = 0, d_min = 0, d_max = 0;
    bit spur_en = 1'b0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wen    (data_wen),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_wstrb   (mem_wstrb),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // kseg0 (0x8000_0000..0x9FFF_FFFF) and kseg1 (0xA000_0000..0xBFFF_FFFF)
    // are windows onto physical 0..512 MiB; everything else passes through.
    function automatic logic [31:0] map_addr(input logic [31:0] va);
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
        if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
        return va;
    endfunction

    function automatic logic [31:0] rd_fn(input logic [31:0] pa);
        return pa * 32'h9E37_79B9 + 32'h1234_5678;
    endfunction

    // Slave: accepts after a programmable delay, returns data later,
    // and optionally throws stray data_ok pulses the arbiter must ignore.
    initial begin
        int          s_ph;
        int          s_cnt;
        logic [31:0] s_pa;
        s_ph = 0; s_cnt = 0; s_pa = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            if (!rst) begin
                s_ph = 0;
            end else begin
                if (s_ph == 1) begin
                    if (s_cnt == 0) begin
                        mem_data_ok = 1'b1;
                        mem_rdata   = rd_fn(s_pa);
                        s_ph        = 0;
                    end else begin
                        s_cnt--;
                    end
                end else if (s_ph == 0 && mem_req) begin
                    s_cnt = $urandom_range(a_max, a_min);
                    s_ph  = 2;
                end
                if (s_ph == 2) begin
                    if (s_cnt == 0) begin
                        mem_addr_ok = 1'b1;
                        s_pa        = mem_addr;
                        s_cnt       = $urandom_range(d_max, d_min);
                        s_ph        = 1;
                    end else begin
                        s_cnt--;
                    end
                end
                if (spur_en && s_ph != 1 && !mem_addr_ok && !mem_data_ok &&
                    $urandom_range(5, 0) == 0) begin
                    mem_data_ok = 1'b1;
                    mem_rdata   = $urandom;
                end
            end
        end
    end

    // Bus monitor: fields held through ADDR, accepted transactions in order.
    initial begin
        bus_t held;
        bus_t e;
        bit   hold_v;
        hold_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check("mem_req held until addr_ok", mem_req, 1'b1);
                    if (mem_req) begin
                        check("mem_addr stable", mem_addr, held.addr);
                        check("mem_wr stable", mem_wr, held.wr);
                        check("mem_wstrb stable", mem_wstrb, held.strb);
                        check("mem_wdata stable", mem_wdata, held.wdata);
                    end
                end
                if (mem_req && mem_addr_ok) begin
                    if (exp_bus.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected bus txn: addr %h wr %b", mem_addr, mem_wr);
                    end else begin
                        e = exp_bus.pop_front();
                        check("mem_addr", mem_addr, e.addr);
                        check("mem_wr", mem_wr, e.wr);
                        check("mem_wstrb", mem_wstrb, e.strb);
                        if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
                    end
                    hold_v = 1'b0;
                end else if (mem_req) begin
                    hold_v      = 1'b1;
                    held.addr   = mem_addr;
                    held.wr     = mem_wr;
                    held.strb   = mem_wstrb;
                    held.wdata  = mem_wdata;
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    end

    // Read-back monitor: when the pipeline is released, both words must match.
    initial begin
        rd_t e;
        forever begin
            @(negedge clk);
            if (rst && !stall && (inst_req || data_req)) begin
                check("all bus txns done at stall release", exp_bus.size(), 0);
                if (exp_rd.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected stall release: inst_rdata %h data_rdata %h",
                             inst_rdata, data_rdata);
                end else begin
                    e = exp_rd.pop_front();
                    check("inst_rdata", inst_rdata, e.irdata);
                    check("data_rdata", data_rdata, e.drdata);
                end
            end
        end
    end

    task automatic wait_stall_low(input string name, input int exp_cyc);
        int cyc;
        bit done;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            if (!stall) done = 1'b1;
            else cyc++;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: stall still high after %0d cycles, required low", name, cyc);
        end else if (exp_cyc >= 0) begin
            check({name, " stall cycles"}, cyc, exp_cyc);
        end
    endtask

    task automatic wait_addr_ok(input string name);
        int cyc;
        bit done;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            if (mem_req && mem_addr_ok) done = 1'b1;
            else cyc++;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no addr_ok within %0d cycles", name, cyc);
        end
    endtask

    task automatic push_bus(input logic [31:0] va, input logic [3:0] wen, input logic [31:0] wd);
        bus_t b;
        b.addr  = map_addr(va);
        b.wr    = (wen != 4'h0);
        b.strb  = wen;
        b.wdata = wd;
        exp_bus.push_back(b);
    endtask

    task automatic push_rd();
        rd_t r;
        r.irdata = m_inst_rd;
        r.drdata = m_data_rd;
        exp_rd.push_back(r);
    endtask

    // One pipeline step: requests held until the arbiter drops stall.
    task automatic do_step(input string name, input logic ir, input logic [31:0] ia,
                           input logic dr, input logic [3:0] dw, input logic [31:0] da,
                           input logic [31:0] dd, input int exp_cyc);
        if (dr) begin
            push_bus(da, dw, dd);
            m_data_rd = rd_fn(map_addr(da));
        end
        if (ir) begin
            push_bus(ia, 4'h0, 32'h0);
            m_inst_rd = rd_fn(map_addr(ia));
        end
        if (ir || dr) push_rd();
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_wen   = dw;
        data_addr  = da;
        data_wdata = dd;
        wait_stall_low(name, exp_cyc);
        @(posedge clk);
        #1;
        inst_req = 1'b0;
        data_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ia, da, dd;
        logic [3:0]  dw;
        int          sel;

        // reset state
        #12;
        check("reset mem_req", mem_req, 1'b0);
        check("reset mem_wr", mem_wr, 1'b0);
        check("reset mem_wstrb", mem_wstrb, 4'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset inst_rdata", inst_rdata, 32'h0);
        check("reset data_rdata", data_rdata, 32'h0);
        check("reset stall", stall, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // single load, minimum latency
        do_step("single load", 1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAF_0010, 32'h0, 3);

        // simultaneous inst fetch and data store
        do_step("simultaneous", 1'b1, 32'h8000_0000, 1'b1, 4'hF, 32'hA000_0100, 32'hDEAD_BEEF, 6);

        // unmapped address passes through
        do_step("unmapped", 1'b1, 32'h0040_0000, 1'b0, 4'h0, 32'h0, 32'h0, 3);

        // slow slave
        a_min = 3; a_max = 3; d_min = 4; d_max = 4;
        do_step("slow slave", 1'b0, 32'h0, 1'b1, 4'h3, 32'h8000_0204, 32'hCAFE_F00D, 10);

        // flush: data request withdrawn while its transaction is in WAIT
        a_min = 0; a_max = 0; d_min = 3; d_max = 3;
        push_bus(32'hA000_2000, 4'h0, 32'h0);
        push_bus(32'h8000_1000, 4'h0, 32'h0);
        m_inst_rd = rd_fn(map_addr(32'h8000_1000));
        push_rd();
        inst_req  = 1'b1;
        inst_addr = 32'h8000_1000;
        data_req  = 1'b1;
        data_wen  = 4'h0;
        data_addr = 32'hA000_2000;
        wait_addr_ok("flush first addr_ok");
        @(posedge clk);
        #1;
        data_req = 1'b0;
        wait_stall_low("flush", -1);
        @(posedge clk);
        #1;
        inst_req = 1'b0;

        // reset while an inst fetch is in WAIT; held request re-issues
        push_bus(32'h9000_0040, 4'h0, 32'h0);
        inst_req  = 1'b1;
        inst_addr = 32'h9000_0040;
        wait_addr_ok("reset-mid-op addr_ok");
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid-op reset mem_req", mem_req, 1'b0);
        check("mid-op reset mem_wr", mem_wr, 1'b0);
        check("mid-op reset mem_wstrb", mem_wstrb, 4'h0);
        check("mid-op reset mem_addr", mem_addr, 32'h0);
        check("mid-op reset mem_wdata", mem_wdata, 32'h0);
        check("mid-op reset inst_rdata", inst_rdata, 32'h0);
        check("mid-op reset data_rdata", data_rdata, 32'h0);
        check("mid-op reset stall with held inst_req", stall, 1'b1);
        m_inst_rd = rd_fn(map_addr(32'h9000_0040));
        m_data_rd = 32'h0;
        push_bus(32'h9000_0040, 4'h0, 32'h0);
        push_rd();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_stall_low("reset re-issue", -1);
        @(posedge clk);
        #1;
        inst_req = 1'b0;

        // randomised traffic with variable slave timing and stray data_ok
        a_min = 0; a_max = 3; d_min = 0; d_max = 4;
        spur_en = 1'b1;
        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(3, 0);
            ia  = $urandom & 32'hFFFF_FFFC;
            da  = $urandom & 32'hFFFF_FFFC;
            dd  = $urandom;
            dw  = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom);
            do_step("random", sel[0], ia, sel[1], dw, da, dd, -1);
        end
        spur_en = 1'b0;
        repeat (3) @(posedge clk);

        check("leftover expected bus txns", exp_bus.size(), 0);
        check("leftover expected read-backs", exp_rd.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
